// File: rtl/tpu_tile_sequencer_64x64.sv
// tpu_tile_sequencer_64x64: runs one matmul tile through bank swap, weight load, activation stream, drain
module tpu_tile_sequencer_64x64 #(
  parameter int ARRAY_SIZE = 64,
  parameter int MAX_K = 4096,
  parameter int DRAIN_CYCLES = 127,
  parameter int ID_W = 8,
  localparam int KW = $clog2(MAX_K)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [KW-1:0]   cmd_k,
  input  logic [ID_W-1:0] cmd_id,
  input  logic            wgt_fill_done,
  input  logic            act_fill_done,
  output logic            wgt_shadow_empty,
  output logic            act_shadow_empty,
  output logic            swap_weight_banks,
  output logic            swap_act_banks,
  output logic            wgt_rd_en,
  output logic [KW-1:0]   wgt_rd_row,
  output logic            act_stream_start,
  output logic [KW-1:0]   act_stream_count,
  input  logic            act_stream_done,
  output logic            tile_done,
  output logic [ID_W-1:0] tile_done_id,
  output logic            tile_err,
  output logic            busy,
  output logic [31:0]     fill_overflow_cnt,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     tile_count
);
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  typedef enum logic [2:0] {IDLE, WAIT_BUF, SWAP, WGT_LOAD, ACT_START, ACT_WAIT, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [KW-1:0] k_q, row;
  logic [ID_W-1:0] id_q;
  logic err_q, wgt_sv, act_sv, wgt_ovf, act_ovf;
  logic [DW-1:0] drain;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (cmd_valid) state_nx = cmd_k == '0 ? DONE : WAIT_BUF;
      WAIT_BUF:  if ((wgt_sv | wgt_fill_done) & (act_sv | act_fill_done)) state_nx = SWAP;
      SWAP:      state_nx = WGT_LOAD;
      WGT_LOAD:  if (row == KW'(ARRAY_SIZE - 1)) state_nx = ACT_START;
      ACT_START: state_nx = ACT_WAIT;
      ACT_WAIT:  if (act_stream_done) state_nx = DRAIN;
      DRAIN:     if (drain == '0) state_nx = DONE;
      default:   state_nx = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = state == IDLE;
    busy = state != IDLE;
    swap_weight_banks = state == SWAP;
    swap_act_banks = state == SWAP;
    wgt_rd_en = state == WGT_LOAD;
    wgt_rd_row = state == WGT_LOAD ? row : '0;
    act_stream_start = state == ACT_START;
    act_stream_count = state == ACT_START ? k_q : '0;
    tile_done = state == DONE;
    tile_done_id = state == DONE ? id_q : '0;
    tile_err = state == DONE && err_q;
    wgt_shadow_empty = !wgt_sv;
    act_shadow_empty = !act_sv;
    wgt_ovf = wgt_fill_done && (wgt_sv || state == SWAP);
    act_ovf = act_fill_done && (act_sv || state == SWAP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k_q <= '0;
      id_q <= '0;
      err_q <= 1'b0;
      row <= '0;
      drain <= '0;
      wgt_sv <= 1'b0;
      act_sv <= 1'b0;
      fill_overflow_cnt <= '0;
      stall_cycles <= '0;
      tile_count <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        k_q <= cmd_k;
        id_q <= cmd_id;
        err_q <= cmd_k == '0;
      end
      row <= state == WGT_LOAD ? row + 1'b1 : '0;
      drain <= state == DRAIN ? drain - 1'b1 : DW'(DRAIN_CYCLES - 1);
      wgt_sv <= state == SWAP ? 1'b0 : wgt_sv | wgt_fill_done;
      act_sv <= state == SWAP ? 1'b0 : act_sv | act_fill_done;
      fill_overflow_cnt <= fill_overflow_cnt + 32'(wgt_ovf) + 32'(act_ovf);
      stall_cycles <= stall_cycles + 32'(state == WAIT_BUF);
      tile_count <= tile_count + 32'(state == DONE);
    end
endmodule
